// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request, IF/ID register (option: FETCH_ALIGN_CHECK_EN)
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall_in,
  input  logic        halt_in,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_busy,
  output logic [15:0] base_pc,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN, S_HALT} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc;
  logic [15:0] pc_seq;
  logic [15:0] target;

  assign pc_seq    = pc + 16'd2;
  // Without the alignment check an odd target is silently rounded down.
  assign target    = redirect_pc & 16'hFFFE;
  assign base_pc   = pc;
  assign imem_addr = pc;
  // Request only while fetching and never during reset.
  assign imem_rd   = (state == S_FETCH) && !rst;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // PC, fetch state machine and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 16'h0000;
      if_instr   <= NOP_INSTR;
      if_pc      <= 16'h0000;
      if_valid   <= 1'b0;
      halted     <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else if (redirect && state != S_HALT) begin
      // Flush IF/ID; any data returned this cycle belongs to the wrong path.
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[0]) begin
        err_q  <= 1'b1;
        halted <= 1'b1;
        state  <= S_HALT;
      end else
`endif
      begin
        pc    <= target;
        state <= (imem_busy && !imem_done) ? S_DRAIN : S_FETCH;
      end
    end else if (halt_in && state != S_HALT) begin
      // Abandon any in-flight access; IF/ID keeps the HALT instruction.
      halted <= 1'b1;
      state  <= S_HALT;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_done) begin
            pc <= pc_seq;
            if (stall_in) begin
              hold_instr <= imem_data;
              hold_pc    <= pc;
              state      <= S_HOLD;
            end else begin
              if_instr <= imem_data;
              if_pc    <= pc;
              if_valid <= 1'b1;
            end
          end else if (!stall_in) begin
            if_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_in) begin
            if_instr <= hold_instr;
            if_pc    <= hold_pc;
            if_valid <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_done) state <= S_FETCH;
        end
        default: begin
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall_in;
  logic        halt_in;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_busy;
  logic [15:0] base_pc;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic        err;

  logic        fast;
  logic        man_done;
  logic [15:0] man_data;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_in(stall_in), .halt_in(halt_in), .imem_rd(imem_rd),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_done(imem_done),
    .imem_busy(imem_busy), .base_pc(base_pc), .if_instr(if_instr),
    .if_pc(if_pc), .if_valid(if_valid), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0006) return 16'hA5A5;
    return 16'h4001 + {1'b0, a[15:1]};
  endfunction

  // Single-cycle memory when fast=1, otherwise driven by hand.
  always_comb begin
    imem_done = fast ? imem_rd : man_done;
    imem_data = fast ? mem_word(imem_addr) : man_data;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; stall_in = 1'b0;
    halt_in = 1'b0; imem_busy = 1'b0; fast = 1'b1; man_done = 1'b0; man_data = 16'h0000;
    step(); step();
    check("rst_rd", {15'd0, imem_rd}, 16'h0000);
    check("rst_instr", if_instr, 16'h0800);
    check("rst_valid", {15'd0, if_valid}, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);
    check("rst_err", {15'd0, err}, 16'h0000);
    check("rst_addr", imem_addr, 16'h0000);
    rst = 1'b0;
    #1;
    check("rd_after_rst", {15'd0, imem_rd}, 16'h0001);

    // One instruction per cycle from a single-cycle memory.
    step();
    check("f0_pc", if_pc, 16'h0000);
    check("f0_instr", if_instr, 16'h4001);
    check("f0_valid", {15'd0, if_valid}, 16'h0001);
    check("f0_base", base_pc, 16'h0002);
    step();
    check("f1_pc", if_pc, 16'h0002);
    check("f1_instr", if_instr, 16'h4002);
    step();
    check("f2_pc", if_pc, 16'h0004);
    check("f2_instr", if_instr, 16'h4003);
    check("f2_addr", imem_addr, 16'h0006);

    // Stall while A5A5 returns: captured in hold buffer.
    stall_in = 1'b1;
    step();
    check("hold_rd", {15'd0, imem_rd}, 16'h0000);
    check("hold_instr", if_instr, 16'h4003);
    check("hold_addr", imem_addr, 16'h0008);
    step(); step();
    check("hold3_rd", {15'd0, imem_rd}, 16'h0000);
    check("hold3_instr", if_instr, 16'h4003);
    stall_in = 1'b0;
    step();
    check("unhold_instr", if_instr, 16'hA5A5);
    check("unhold_pc", if_pc, 16'h0006);
    check("unhold_valid", {15'd0, if_valid}, 16'h0001);
    check("unhold_addr", imem_addr, 16'h0008);
    step();
    check("after_hold_pc", if_pc, 16'h0008);
    check("after_hold_instr", if_instr, 16'h4005);

    // Redirect while an access is outstanding: drain and discard.
    fast = 1'b0; imem_busy = 1'b1; man_done = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    check("rdir_valid", {15'd0, if_valid}, 16'h0000);
    check("rdir_instr", if_instr, 16'h0800);
    check("rdir_addr", imem_addr, 16'h0100);
    check("drain_rd", {15'd0, imem_rd}, 16'h0000);
    step();
    check("drain2_rd", {15'd0, imem_rd}, 16'h0000);
    man_done = 1'b1; man_data = 16'hDEAD;
    step();
    man_done = 1'b0; imem_busy = 1'b0;
    check("drained_valid", {15'd0, if_valid}, 16'h0000);
    check("drained_instr", if_instr, 16'h0800);
    check("drained_rd", {15'd0, imem_rd}, 16'h0001);
    check("drained_addr", imem_addr, 16'h0100);
    fast = 1'b1;
    step();
    check("tgt_pc", if_pc, 16'h0100);
    check("tgt_instr", if_instr, 16'h4081);

    // Redirect to FFFE with idle memory, then wrap.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    check("wrap_flush", {15'd0, if_valid}, 16'h0000);
    check("wrap_addr0", imem_addr, 16'hFFFE);
    step();
    check("wrap_ifpc", if_pc, 16'hFFFE);
    check("wrap_instr", if_instr, 16'hC000);
    check("wrap_valid", {15'd0, if_valid}, 16'h0001);
    check("wrap_addr", imem_addr, 16'h0000);

    // Redirect beats halt in the same cycle.
    redirect = 1'b1; halt_in = 1'b1; redirect_pc = 16'h0200;
    step();
    redirect = 1'b0;
    check("rh_addr", imem_addr, 16'h0200);
    check("rh_halted", {15'd0, halted}, 16'h0000);
    step();
    halt_in = 1'b0;
    check("halt_halted", {15'd0, halted}, 16'h0001);
    check("halt_rd", {15'd0, imem_rd}, 16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0400;
    step(); step();
    redirect = 1'b0;
    check("halt_stay", {15'd0, halted}, 16'h0001);
    check("halt_rd2", {15'd0, imem_rd}, 16'h0000);
    check("halt_noredir", imem_addr, 16'h0200);
    check("halt_valid", {15'd0, if_valid}, 16'h0000);

    // Reset in the middle of HALT.
    #2 rst = 1'b1;
    #1;
    check("rst_halt_halted", {15'd0, halted}, 16'h0000);
    check("rst_halt_addr", imem_addr, 16'h0000);
    rst = 1'b0;

    // Misaligned redirect target.
    redirect = 1'b1; redirect_pc = 16'h0203;
    step();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("align_err", {15'd0, err}, 16'h0001);
    check("align_halted", {15'd0, halted}, 16'h0001);
    check("align_addr", imem_addr, 16'h0000);
`else
    check("align_err", {15'd0, err}, 16'h0000);
    check("align_halted", {15'd0, halted}, 16'h0000);
    check("align_addr", imem_addr, 16'h0202);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit pipeline.
- Owns the architectural PC register and drives the instruction-memory request.
- Latches the fetched instruction and its PC into the IF/ID register.
- Consumes the resolved target from the PC adder on redirect, and exports the current fetch PC as the adder's base PC.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, encoding placed in IF/ID on reset and flush

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
redirect  input  1  taken branch/jump resolved; load redirect_pc
redirect_pc  input  16  target PC from PC adder
stall_in  input  1  decode not ready; hold IF/ID
halt_in  input  1  HALT decoded in IF/ID instruction
imem_rd  output  1  memory read request
imem_addr  output  16  memory address (= pc)
imem_data  input  16  read data, valid when imem_done=1
imem_done  input  1  access complete this cycle
imem_busy  input  1  access outstanding
base_pc  output  16  current fetch PC, to PC adder
if_instr  output  16  IF/ID instruction
if_pc  output  16  IF/ID PC of if_instr
if_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch permanently stopped
err  output  1  sticky alignment error (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; state=FETCH.
  - if_instr=NOP_INSTR, if_pc=0, if_valid=0, halted=0, err=0.
  - hold buffer empty; imem_rd=0 while rst high.
- base_pc=imem_addr=pc at all times. Sequential PC is pc+2, mod 2^16 (16'hFFFE wraps to 16'h0000). pc is always even.
- IF/ID register updates only in cycles with stall_in=0, except for flush on redirect.
- FETCH state:
  - imem_rd=1.
  - imem_done=1, stall_in=0: if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+2.
  - imem_done=1, stall_in=1: capture imem_data and pc in hold buffer, pc<=pc+2, go to HOLD.
  - imem_done=0, stall_in=0: if_valid<=0 (bubble).
  - imem_done=0, stall_in=1: IF/ID unchanged.
- HOLD state:
  - imem_rd=0.
  - When stall_in=0: IF/ID<=hold buffer, if_valid<=1, go to FETCH.
- DRAIN state:
  - imem_rd=0.
  - Wait for imem_done; discard data, go to FETCH. pc already holds the target.
- HALT state:
  - imem_rd=0, halted=1, if_valid<=0.
  - Exited only by rst.
- Redirect (priority over everything except rst; ignored in HALT):
  - pc<=target; if_instr<=NOP_INSTR, if_valid<=0; hold buffer dropped.
  - Data returned in the same cycle is discarded.
  - Next state: DRAIN if imem_busy=1 and imem_done=0, else FETCH.
- halt_in=1 with redirect=0 (any state except HALT): go to HALT next cycle. An in-flight access is abandoned; its data is ignored.
- Simultaneous redirect and halt_in: redirect wins, no halt.
- Latency: a single-cycle memory (done in the request cycle) gives one instruction per cycle. Redirect-to-first-valid = 2 cycles with an idle memory.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[0]=1 sets err=1 (sticky until rst) and goes to HALT.
  - IF/ID is flushed; pc is not updated.
- Not defined:
  - redirect_pc[0] is forced to 0 on load.
  - err is tied to 0.

Test Plan:
- Reset with RESET_PC=0, 1-cycle memory returning 16'h4001/16'h4002/16'h4003, stall_in=0 -> if_pc 0000, 0002, 0004 on consecutive cycles, if_valid=1 from cycle 2, imem_addr increments by 2.
- stall_in held high 3 cycles while done=1 returns 16'hA5A5 at pc 0006 -> state HOLD, imem_rd=0, if_instr unchanged. Then stall_in=0 -> if_instr=A5A5, if_pc=0006, next fetch from 0008.
- redirect with redirect_pc=16'h0100 while imem_busy=1 (done 2 cycles later) -> if_valid=0, if_instr=0800, returned data discarded, next imem_addr=0100 with imem_rd=1.
- pc=16'hFFFE, done=1 -> pc wraps to 0000, if_pc=FFFE.
- halt_in=1 and redirect=1 same cycle -> pc=target, halted=0. Later halt_in alone -> halted=1 and imem_rd=0 forever until rst; rst mid-HALT -> pc=RESET_PC, halted=0.
- redirect_pc=16'h0203: with FETCH_ALIGN_CHECK_EN -> err=1, halted=1; without it -> pc=0202, err=0.
